// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq; the producer/consumer side uses
// the master modport and the adder sequencer uses slave. in_sub exists only under WIDE_ADD_SUB_EN.
interface wide_add_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 32 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef WIDE_ADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin,
`ifdef WIDE_ADD_SUB_EN
        output in_sub,
`endif
        output out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin,
`ifdef WIDE_ADD_SUB_EN
        input  in_sub,
`endif
        input  out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/wide_add_seq.sv
// Wide-operand adder sequencer: one shared adder_32 walks the operands LSW first, rippling carry
// through a register. Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [WORDS-1:0][31:0]  a_q, b_q;
    logic [WORDS-1:0][31:0]  sum_q, sum_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    load;

    logic [32*WORDS-1:0]     b_load;
    logic                    carry_init;
    logic [31:0]             a_word, b_word, add_sum;
    logic                    add_cout;

    // Subtraction is A + ~B + 1: invert B on capture and force the initial carry.
`ifdef WIDE_ADD_SUB_EN
    assign b_load     = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign carry_init = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    assign b_load     = bus.in_b;
    assign carry_init = bus.in_cin;
`endif

    // Word select kept apart from the FSM block so the adder is not inside a combinational loop.
    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_word = a_q[i];
                b_word = b_q[i];
            end
        end
    end

    adder_32 u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    carry_d = carry_init;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[i] = add_sum;
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= bus.in_a;
            b_q <= b_load;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: WORDS=4 and WORDS=1 instances, directed table,
// hand-written multi-cycle sequences and randomized adds against a plain-arithmetic model.
module tb_wide_add_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wide_add_seq_if #(.WORDS(4)) bus4 ();
    wide_add_seq_if #(.WORDS(1)) bus1 ();

    wide_add_seq #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    wide_add_seq #(.WORDS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        string        name;
        logic [127:0] a;
        logic [127:0] b;
        logic         cin;
        logic [127:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    localparam logic [127:0] ONES = {128{1'b1}};

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [128:0] model(input logic [127:0] a, input logic [127:0] b,
                                           input logic cin, input logic sub);
        logic [127:0] bb;
        logic         c;
        bb = b;
        c  = cin;
        if (sub) begin
            bb = ~b;
            c  = 1'b1;
        end
        return {1'b0, a} + {1'b0, bb} + {128'd0, c};
    endfunction

    // Accept one operand set on the WORDS=4 instance; report result and accept-to-valid latency.
    task automatic run4(input logic [127:0] a, input logic [127:0] b, input logic cin,
                        input logic sub, output logic [127:0] sum, output logic cout,
                        output int lat);
        int guard;
        guard = 0;
        while (!bus4.in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        bus4.in_a = a;
        bus4.in_b = b;
        bus4.in_cin = cin;
`ifdef WIDE_ADD_SUB_EN
        bus4.in_sub = sub;
`endif
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        sum  = bus4.out_sum;
        cout = bus4.out_cout;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
    endtask

    task automatic run1(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] sum, output logic cout, output int lat);
        int guard;
        guard = 0;
        while (!bus1.in_ready && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        bus1.in_a = a;
        bus1.in_b = b;
        bus1.in_cin = cin;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        sum  = bus1.out_sum;
        cout = bus1.out_cout;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[7];
        logic [127:0] sum, a, b, exp_sum;
        logic [31:0]  sum1;
        logic         cout, cin, sub, exp_cout;
        logic [128:0] ref_v;
        int           lat, guard;

        vecs[0] = '{"full_ripple", ONES, 128'd1, 1'b0, 128'd0, 1'b1};
        vecs[1] = '{"word_boundary", 128'hFFFF_FFFF, 128'd0, 1'b1, 128'h1_0000_0000, 1'b0};
        vecs[2] = '{"small_3p4", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0};
        vecs[3] = '{"cin_only", 128'd0, 128'd0, 1'b1, 128'd1, 1'b0};
        vecs[4] = '{"all_ones_cin", ONES, ONES, 1'b1, ONES, 1'b1};
        vecs[5] = '{"msb_overflow", {1'b1, 127'd0}, {1'b1, 127'd0}, 1'b0, 128'd0, 1'b1};
        vecs[6] = '{"three_word_ripple", {32'd0, {96{1'b1}}}, 128'd1, 1'b0,
                    {31'd0, 1'b1, 96'd0}, 1'b0};

        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
        bus1.out_ready = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        bus4.in_sub = 1'b0;
        bus1.in_sub = 1'b0;
`endif

        // Reset held for two edges.
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset_in_ready", 160'(bus4.in_ready), 160'(1'b1));
        check("reset_out_valid", 160'(bus4.out_valid), 160'(1'b0));
        check("reset_out_sum", 160'(bus4.out_sum), 160'(0));
        check("reset_out_cout", 160'(bus4.out_cout), 160'(1'b0));
        check("reset_w1_in_ready", 160'(bus1.in_ready), 160'(1'b1));
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, sum, cout, lat);
            check({vecs[i].name, "_sum"}, 160'(sum), 160'(vecs[i].exp_sum));
            check({vecs[i].name, "_cout"}, 160'(cout), 160'(vecs[i].exp_cout));
            check({vecs[i].name, "_latency"}, 160'(lat), 160'(4));
        end

        // Single-word instance: same word-boundary operands wrap to 0 with carry out.
        run1(32'hFFFF_FFFF, 32'd0, 1'b1, sum1, cout, lat);
        check("w1_sum", 160'(sum1), 160'(0));
        check("w1_cout", 160'(cout), 160'(1'b1));
        check("w1_latency", 160'(lat), 160'(1));

        // Backpressure: result held while new operands are offered and must be ignored.
        bus4.in_a = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        bus4.in_b = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        bus4.in_cin = 1'b1;
        ref_v = model(bus4.in_a, bus4.in_b, 1'b1, 1'b0);
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        guard = 0;
        while (!bus4.out_valid && guard < 40) begin
            @(posedge clk); #1; guard++;
        end
        check("bp_first_sum", 160'(bus4.out_sum), 160'(ref_v[127:0]));
        check("bp_first_cout", 160'(bus4.out_cout), 160'(ref_v[128]));
        for (int i = 0; i < 10; i++) begin
            bus4.in_a = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus4.in_b = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus4.in_valid = 1'(i % 2);
            @(posedge clk); #1;
            check("bp_hold_valid", 160'(bus4.out_valid), 160'(1'b1));
            check("bp_hold_in_ready", 160'(bus4.in_ready), 160'(1'b0));
            check("bp_hold_sum", 160'(bus4.out_sum), 160'(ref_v[127:0]));
            check("bp_hold_cout", 160'(bus4.out_cout), 160'(ref_v[128]));
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        check("bp_release_valid", 160'(bus4.out_valid), 160'(1'b0));
        check("bp_release_in_ready", 160'(bus4.in_ready), 160'(1'b1));
        @(posedge clk); #1;
        check("bp_nothing_captured", 160'(bus4.in_ready), 160'(1'b1));

        // Reset on the second RUN cycle, then a clean add.
        bus4.in_a = ONES;
        bus4.in_b = ONES;
        bus4.in_cin = 1'b1;
        bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 160'(bus4.in_ready), 160'(1'b1));
        check("midrst_out_valid", 160'(bus4.out_valid), 160'(1'b0));
        check("midrst_out_sum", 160'(bus4.out_sum), 160'(0));
        check("midrst_out_cout", 160'(bus4.out_cout), 160'(1'b0));
        run4(128'd3, 128'd4, 1'b0, 1'b0, sum, cout, lat);
        check("midrst_after_sum", 160'(sum), 160'(7));
        check("midrst_after_cout", 160'(cout), 160'(1'b0));
        check("midrst_after_latency", 160'(lat), 160'(4));

`ifdef WIDE_ADD_SUB_EN
        run4(128'd5, 128'd7, 1'b0, 1'b1, sum, cout, lat);
        check("sub_5m7_sum", 160'(sum), 160'(ONES - 128'd1));
        check("sub_5m7_cout", 160'(cout), 160'(1'b0));
        run4(128'd7, 128'd5, 1'b0, 1'b1, sum, cout, lat);
        check("sub_7m5_sum", 160'(sum), 160'(2));
        check("sub_7m5_cout", 160'(cout), 160'(1'b1));
`endif

        // Randomized adds against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            a   = {$urandom(), $urandom(), $urandom(), $urandom()};
            b   = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i % 6 == 0) b = ~a;
            cin = 1'($urandom_range(0, 1));
            sub = 1'b0;
`ifdef WIDE_ADD_SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            ref_v    = model(a, b, cin, sub);
            exp_sum  = ref_v[127:0];
            exp_cout = ref_v[128];
            run4(a, b, cin, sub, sum, cout, lat);
            check("rand_sum", 160'(sum), 160'(exp_sum));
            check("rand_cout", 160'(cout), 160'(exp_cout));
            check("rand_latency", 160'(lat), 160'(4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
